// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port 2Kx32 data memory between the execute
// stage (port 0) and the debug/loader path (port 1). Optional macro: DMEM_ARB_FIXED_PRIO_EN.
module dmem_arbiter #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic              mem_oen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_d,
    input  logic [DATA_W-1:0] mem_q,
    output logic [8:0]        dbg_state
);

    // Handshake: a requester holds pX_req with stable we/addr/wdata until it sees pX_gnt
    // high in the same cycle; that cycle performs the access. Reads return pX_rvalid with
    // pX_rdata exactly one cycle after the grant. There is no ready/backpressure on returns.

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_P0   = 2'd1,
        SEL_P1   = 2'd2
    } sel_t;

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST - 1);

    sel_t       owner_q, owner_d;
    sel_t       rd_tag_q, rd_tag_d;
    sel_t       win;
    logic       last_q, last_d;      // 0: port 0 won most recently, 1: port 1
    logic [3:0] burst_cnt_q, burst_cnt_d;

    always_comb begin
        win = SEL_NONE;
        if (rst) begin
            win = SEL_NONE;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        end else if (p0_req) begin
            win = SEL_P0;
        end else if (p1_req) begin
            win = SEL_P1;
        end
`else
        end else if (p0_req && p1_req) begin
            case (owner_q)
                SEL_P0: begin
                    if (burst_cnt_q < BURST_LIM) win = SEL_P0;
                    else                         win = SEL_P1;
                end
                SEL_P1: begin
                    if (burst_cnt_q < BURST_LIM) win = SEL_P1;
                    else                         win = SEL_P0;
                end
                default: begin
                    if (last_q) win = SEL_P0;
                    else        win = SEL_P1;
                end
            endcase
        end else if (p0_req) begin
            win = SEL_P0;
        end else if (p1_req) begin
            win = SEL_P1;
        end
`endif
    end

    always_comb begin
        p0_gnt   = 1'b0;
        p1_gnt   = 1'b0;
        mem_cen  = 1'b1;
        mem_wen  = 1'b1;
        mem_oen  = 1'b0;
        mem_addr = '0;
        mem_d    = '0;
        case (win)
            SEL_P0: begin
                p0_gnt   = 1'b1;
                mem_cen  = 1'b0;
                mem_wen  = ~p0_we;
                mem_addr = p0_addr;
                mem_d    = p0_wdata;
            end
            SEL_P1: begin
                p1_gnt   = 1'b1;
                mem_cen  = 1'b0;
                mem_wen  = ~p1_we;
                mem_addr = p1_addr;
                mem_d    = p1_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        last_d      = last_q;
        rd_tag_d    = SEL_NONE;
        if (win == SEL_NONE) begin
            owner_d     = SEL_NONE;
            burst_cnt_d = 4'd0;
        end else if (win == owner_q) begin
            if (burst_cnt_q != 4'hF) burst_cnt_d = burst_cnt_q + 4'd1;
        end else begin
            owner_d     = win;
            burst_cnt_d = 4'd0;
            last_d      = (win == SEL_P1);
        end
        if (win == SEL_P0 && !p0_we) rd_tag_d = SEL_P0;
        if (win == SEL_P1 && !p1_we) rd_tag_d = SEL_P1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= SEL_NONE;
            burst_cnt_q <= 4'd0;
            last_q      <= 1'b1;
            rd_tag_q    <= SEL_NONE;
        end else begin
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            last_q      <= last_d;
            rd_tag_q    <= rd_tag_d;
        end
    end

    // A read granted just before reset must not surface while reset is held.
    assign p0_rvalid = (rd_tag_q == SEL_P0) && !rst;
    assign p1_rvalid = (rd_tag_q == SEL_P1) && !rst;
    assign p0_rdata  = p0_rvalid ? mem_q : '0;
    assign p1_rdata  = p1_rvalid ? mem_q : '0;

    assign dbg_state = {owner_q, last_q, burst_cnt_q, rd_tag_q};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural memory macro model
// and a read-return scoreboard.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [10:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_cen, mem_wen, mem_oen;
    logic [10:0] mem_addr;
    logic [31:0] mem_d, mem_q;
    logic [8:0]  dbg_state;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    int          n_chk;
    int          n_pass;
    logic [32:0] exp_q[$];
    logic [31:0] mem [0:2047];

    dmem_arbiter #(.ADDR_W(11), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_oen(mem_oen),
        .mem_addr(mem_addr), .mem_d(mem_d), .mem_q(mem_q),
        .dbg_state(dbg_state)
    );

    // clock / memory macro model
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (!mem_cen) begin
            if (!mem_wen) mem[mem_addr] <= mem_d;
            else          mem_q <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        else             n_pass++;
    endtask

    // driver tasks: inputs change 1ns after the edge, checks 2ns later
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_p0(input logic r, input logic w, input logic [10:0] a, input logic [31:0] d);
        p0_req = r; p0_we = w; p0_addr = a; p0_wdata = d;
    endtask

    task automatic set_p1(input logic r, input logic w, input logic [10:0] a, input logic [31:0] d);
        p1_req = r; p1_we = w; p1_addr = a; p1_wdata = d;
    endtask

    task automatic idle();
        set_p0(1'b0, 1'b0, 11'h0, 32'h0);
        set_p1(1'b0, 1'b0, 11'h0, 32'h0);
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        idle();
        settle();
        cyc();
        rst = 1'b0;
    endtask

    // scoreboard: every rvalid pops one expected {port, data}
    always @(negedge clk) begin
        if (p0_rvalid || p1_rvalid) begin
            check("rvalid_onehot", 32'(p0_rvalid & p1_rvalid), 32'd0);
            if (exp_q.size() == 0) begin
                check("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("rd_port", 32'(p1_rvalid), 32'(e[32]));
                check("rd_data", p1_rvalid ? p1_rdata : p0_rdata, e[31:0]);
                check("rd_other_zero", p1_rvalid ? p0_rdata : p1_rdata, 32'd0);
            end
        end
    end

    initial begin
        logic exp_p0;
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        idle();

        // reset gating with both ports requesting
        cyc();
        set_p0(1'b1, 1'b0, 11'h001, 32'h0);
        set_p1(1'b1, 1'b1, 11'h002, 32'h1);
        settle();
        check("rst_p0_gnt", 32'(p0_gnt), 32'd0);
        check("rst_p1_gnt", 32'(p1_gnt), 32'd0);
        check("rst_cen", 32'(mem_cen), 32'd1);
        check("rst_wen", 32'(mem_wen), 32'd1);
        cyc();
        rst = 1'b0;
        idle();
        settle();
        check("rst_state", 32'(dbg_state), 32'h040);
        check("rst_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'd0);
        check("idle_cen", 32'(mem_cen), 32'd1);
        check("idle_addr", 32'(mem_addr), 32'd0);
        check("oen", 32'(mem_oen), 32'd0);

        // p1 write then p0 read-back
        cyc();
        set_p1(1'b1, 1'b1, 11'h005, 32'hDEADBEEF);
        settle();
        check("wr_p1_gnt", 32'(p1_gnt), 32'd1);
        check("wr_p0_gnt", 32'(p0_gnt), 32'd0);
        check("wr_cen", 32'(mem_cen), 32'd0);
        check("wr_wen", 32'(mem_wen), 32'd0);
        check("wr_addr", 32'(mem_addr), 32'h005);
        check("wr_d", mem_d, 32'hDEADBEEF);
        cyc();
        idle();
        set_p0(1'b1, 1'b0, 11'h005, 32'h0);
        settle();
        check("rd_p0_gnt", 32'(p0_gnt), 32'd1);
        check("rd_wen", 32'(mem_wen), 32'd1);
        check("wr_no_rvalid", 32'(p1_rvalid), 32'd0);
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        cyc();
        idle();
        settle();
        check("rd_p0_rvalid", 32'(p0_rvalid), 32'd1);
        check("rd_p0_rdata", p0_rdata, 32'hDEADBEEF);
        check("idle_d", mem_d, 32'd0);

        // both requesting from reset: 4/4 round robin
        do_reset();
        set_p0(1'b1, 1'b1, 11'h100, 32'hA0);
        set_p1(1'b1, 1'b1, 11'h200, 32'hB0);
        settle();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                cyc();
                settle();
            end
            exp_p0 = FIXED ? 1'b1 : (((i / 4) % 2) == 0);
            check($sformatf("rr_p0_gnt_%0d", i), 32'(p0_gnt), 32'(exp_p0));
            check($sformatf("rr_p1_gnt_%0d", i), 32'(p1_gnt), 32'(!exp_p0));
        end

        // p0 alone until the burst counter saturates, then p1 joins
        for (int i = 0; i < 16; i++) begin
            cyc();
            set_p1(1'b0, 1'b0, 11'h0, 32'h0);
            settle();
            check($sformatf("solo_p0_gnt_%0d", i), 32'(p0_gnt), 32'd1);
        end
        cyc();
        set_p1(1'b1, 1'b1, 11'h201, 32'hB1);
        settle();
        check("sat_cnt", 32'(dbg_state[5:2]), 32'd15);
        check("join_p1_gnt", 32'(p1_gnt), FIXED ? 32'd0 : 32'd1);
        check("join_p0_gnt", 32'(p0_gnt), FIXED ? 32'd1 : 32'd0);
        cyc();
        idle();
        settle();
        check("join_owner", 32'(dbg_state[8:7]), FIXED ? 32'd1 : 32'd2);
        check("join_cnt", 32'(dbg_state[5:2]), FIXED ? 32'd15 : 32'd0);

        // preload and alternating reads
        cyc();
        set_p1(1'b1, 1'b1, 11'h010, 32'h11111111);
        settle();
        cyc();
        set_p1(1'b1, 1'b1, 11'h011, 32'h22222222);
        settle();
        cyc();
        set_p1(1'b0, 1'b0, 11'h0, 32'h0);
        set_p0(1'b1, 1'b0, 11'h010, 32'h0);
        settle();
        check("alt_p0_gnt", 32'(p0_gnt), 32'd1);
        exp_q.push_back({1'b0, 32'h11111111});
        cyc();
        set_p0(1'b0, 1'b0, 11'h0, 32'h0);
        set_p1(1'b1, 1'b0, 11'h011, 32'h0);
        settle();
        check("alt_p1_gnt", 32'(p1_gnt), 32'd1);
        check("alt_p0_rvalid", 32'(p0_rvalid), 32'd1);
        check("alt_p1_quiet", 32'(p1_rvalid), 32'd0);
        exp_q.push_back({1'b1, 32'h22222222});
        cyc();
        idle();
        settle();
        check("alt_p1_rvalid", 32'(p1_rvalid), 32'd1);
        check("alt_p0_quiet", 32'(p0_rvalid), 32'd0);
        check("alt_p1_rdata", p1_rdata, 32'h22222222);

        // reset mid-burst right after a granted read
        do_reset();
        set_p0(1'b1, 1'b1, 11'h020, 32'hC0);
        settle();
        cyc();
        settle();
        cyc();
        set_p0(1'b1, 1'b0, 11'h010, 32'h0);
        settle();
        check("mid_rd_gnt", 32'(p0_gnt), 32'd1);
        cyc();
        rst = 1'b1;
        set_p1(1'b1, 1'b1, 11'h021, 32'hC1);
        settle();
        check("mid_rst_p0_gnt", 32'(p0_gnt), 32'd0);
        check("mid_rst_p1_gnt", 32'(p1_gnt), 32'd0);
        check("mid_rst_cen", 32'(mem_cen), 32'd1);
        check("mid_rst_rvalid", 32'(p0_rvalid), 32'd0);
        cyc();
        rst = 1'b0;
        set_p0(1'b1, 1'b1, 11'h022, 32'hC2);
        settle();
        check("post_rst_rvalid", 32'(p0_rvalid), 32'd0);
        check("post_rst_state", 32'(dbg_state), 32'h040);
        check("post_rst_p0_gnt", 32'(p0_gnt), 32'd1);
        check("post_rst_p1_gnt", 32'(p1_gnt), 32'd0);

        // 8 cycles of contention, then p0 drops
        do_reset();
        set_p0(1'b1, 1'b1, 11'h030, 32'hD0);
        set_p1(1'b1, 1'b1, 11'h031, 32'hD1);
        settle();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                cyc();
                settle();
            end
            exp_p0 = FIXED ? 1'b1 : (i < 4);
            check($sformatf("ct_p0_gnt_%0d", i), 32'(p0_gnt), 32'(exp_p0));
            check($sformatf("ct_p1_gnt_%0d", i), 32'(p1_gnt), 32'(!exp_p0));
        end
        cyc();
        set_p0(1'b0, 1'b0, 11'h0, 32'h0);
        settle();
        check("drop_p1_gnt", 32'(p1_gnt), 32'd1);
        check("drop_p0_gnt", 32'(p0_gnt), 32'd0);
        cyc();
        idle();
        cyc();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
